// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scanner: per-digit buffer (hex or raw), one digit per
// 2^SLOT_W-cycle slot, PWM brightness, anti-ghost blank and frame strobe.
module seg_scan_mux #(
    parameter int DIGITS         = 10,
    parameter int SLOT_W         = 10,
    parameter int BRIGHT_W       = 4,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [$clog2(DIGITS)-1:0] wr_addr,
    input  logic [7:0]                wr_data,
    input  logic                      wr_raw,
    input  logic [BRIGHT_W-1:0]       brightness,
    input  logic                      enable,
    output logic [DIGITS-1:0]         sel,
    output logic [7:0]                segm,
    output logic                      frame_tick
);
    localparam int AW = $clog2(DIGITS);
    localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [AW:0]       DIGITS_EXT = (AW + 1)'(DIGITS);
    localparam logic [AW-1:0]     LAST_DIGIT = AW'(DIGITS - 1);
    // raw=1, data=0 shows nothing regardless of polarity
    localparam logic [8:0]        BLANK_ENTRY = 9'h100;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    logic [8:0]          buf_q [DIGITS];
    logic [8:0]          buf_d [DIGITS];
    logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
    logic [AW-1:0]       digit_idx_q, digit_idx_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic [7:0]          segm_q, segm_d;
    logic                frame_tick_q, frame_tick_d;
    logic [8:0]          entry_s;
    logic [7:0]          pattern_s;
    logic [DIGITS-1:0]   onehot_s;
    logic                lit_s;

    // Next-state logic for counters, buffer and output registers
    always_comb begin
        slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        if (slot_cnt_q == {SLOT_W{1'b1}}) begin
            if (digit_idx_q == LAST_DIGIT) begin
                digit_idx_d = {AW{1'b0}};
            end else begin
                digit_idx_d = digit_idx_q + AW'(1);
            end
        end else begin
            digit_idx_d = digit_idx_q;
        end

        buf_d = buf_q;
        if (wr_en && ({1'b0, wr_addr} < DIGITS_EXT)) begin
            buf_d[wr_addr] = {wr_raw, wr_data};
        end else begin
            buf_d = buf_q;
        end

        entry_s   = buf_q[digit_idx_q];
        pattern_s = entry_s[8] ? entry_s[7:0] : {entry_s[7], hex_decode(entry_s[3:0])};
        onehot_s  = DIGITS'(1) << digit_idx_q;
        lit_s     = enable && (slot_cnt_q != {SLOT_W{1'b0}})
                    && (slot_cnt_q[SLOT_W-1 -: BRIGHT_W] < brightness);

        // XOR with the idle level applies the pad polarity
        if (lit_s) begin
            sel_d  = onehot_s ^ SEL_OFF;
            segm_d = pattern_s ^ SEG_OFF;
        end else begin
            sel_d  = SEL_OFF;
            segm_d = SEG_OFF;
        end

        frame_tick_d = (digit_idx_q == {AW{1'b0}}) && (slot_cnt_q == {SLOT_W{1'b0}});
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                buf_q[i] <= BLANK_ENTRY;
            end
            slot_cnt_q   <= {SLOT_W{1'b0}};
            digit_idx_q  <= {AW{1'b0}};
            sel_q        <= SEL_OFF;
            segm_q       <= SEG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            buf_q        <= buf_d;
            slot_cnt_q   <= slot_cnt_d;
            digit_idx_q  <= digit_idx_d;
            sel_q        <= sel_d;
            segm_q       <= segm_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign sel        = sel_q;
    assign segm       = segm_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux (4 digits, 16-cycle slots, 2-bit brightness, active-low),
// plus a 5-digit instance to reach out-of-range write addresses.
module tb_seg_scan_mux;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_raw = 1'b0;
    logic [1:0] brightness = 2'd0;
    logic       enable = 1'b0;
    logic [3:0] sel;
    logic [7:0] segm;
    logic       frame_tick;

    logic       wr_en5 = 1'b0;
    logic [2:0] wr_addr5 = 3'd0;
    logic [7:0] wr_data5 = 8'h00;
    logic       wr_raw5 = 1'b0;
    logic [4:0] sel5;
    logic [7:0] segm5;
    logic       frame_tick5;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(.DIGITS(4), .SLOT_W(4), .BRIGHT_W(2), .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_raw(wr_raw), .brightness(brightness), .enable(enable),
        .sel(sel), .segm(segm), .frame_tick(frame_tick)
    );

    seg_scan_mux #(.DIGITS(5), .SLOT_W(4), .BRIGHT_W(2), .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) dut5 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en5), .wr_addr(wr_addr5), .wr_data(wr_data5),
        .wr_raw(wr_raw5), .brightness(brightness), .enable(enable),
        .sel(sel5), .segm(segm5), .frame_tick(frame_tick5)
    );

    // Reference model: position in the scan is just the edge count since reset
    logic [6:0]  dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int unsigned edge_cnt;
    logic [8:0]  m_buf [4];
    logic [3:0]  exp_sel;
    logic [7:0]  exp_segm;
    logic        exp_tick;

    function automatic logic [7:0] model_pattern(input logic [8:0] e);
        logic [3:0] nib;
        nib = e[3:0];
        if (e[8]) return e[7:0];
        return {e[7], dec_tab[nib]};
    endfunction

    function automatic logic model_lit(input int unsigned pos, input logic en, input logic [1:0] br);
        int unsigned s;
        s = pos % 16;
        return en && (s != 0) && ((s / 4) < br);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= 0;
            for (int i = 0; i < 4; i++) m_buf[i] <= 9'h100;
            exp_sel  <= 4'hF;
            exp_segm <= 8'hFF;
            exp_tick <= 1'b0;
        end else begin
            if (model_lit(edge_cnt, enable, brightness)) begin
                exp_sel  <= ~(4'b0001 << ((edge_cnt / 16) % 4));
                exp_segm <= ~model_pattern(m_buf[(edge_cnt / 16) % 4]);
            end else begin
                exp_sel  <= 4'hF;
                exp_segm <= 8'hFF;
            end
            exp_tick <= ((edge_cnt % 64) == 0);
            if (wr_en) m_buf[wr_addr] <= {wr_raw, wr_data};
            edge_cnt <= edge_cnt + 1;
        end
    end

    task automatic drive_write(input logic [1:0] a, input logic [7:0] d, input logic raw);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_raw = raw;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic drive_write5(input logic [2:0] a, input logic [7:0] d, input logic raw);
        wr_en5 = 1'b1; wr_addr5 = a; wr_data5 = d; wr_raw5 = raw;
        @(negedge clk);
        wr_en5 = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        int mm;
        int bad;
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;
        brightness = 2'd3;
        drive_write(2'd0, 8'h08, 1'b0);
        drive_write(2'd1, 8'h3C, 1'b1);
        drive_write(2'd2, 8'h85, 1'b0);
        drive_write(2'd3, 8'hFF, 1'b1);
        repeat (27) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (sel !== 4'hF) begin n_fail++; $display("FAIL reset_sel: got %h want %h", sel, 4'hF); end
        n_tests++;
        if (segm !== 8'hFF) begin n_fail++; $display("FAIL reset_segm: got %h want %h", segm, 8'hFF); end
        n_tests++;
        if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", frame_tick); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL first_tick: got %b want 1", frame_tick); end
        n = 0;
        mm = 0;
        bad = 0;
        do begin
            @(negedge clk);
            n++;
            if (segm !== 8'hFF) bad++;
            if ((sel !== exp_sel) || (segm !== exp_segm) || (frame_tick !== exp_tick)) mm++;
        end while ((frame_tick !== 1'b1) && (n < 200));
        n_tests++;
        if (n != 64) begin n_fail++; $display("FAIL tick_period: got %0d cycles want 64", n); end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL blank_after_reset: got %0d lit-segment cycles want 0", bad); end
        n_tests++;
        if (mm != 0) begin n_fail++; $display("FAIL model_reset: got %0d mismatching cycles want 0", mm); end
    endtask

    task automatic test_hex_decode();
        int hits;
        int mm;
        logic [7:0] want;
        want = ~8'hF7;
        brightness = 2'd3;
        enable = 1'b1;
        drive_write(2'd2, 8'h8A, 1'b0);
        @(negedge clk);
        hits = 0;
        mm = 0;
        repeat (64) begin
            @(negedge clk);
            if ((sel === 4'b1011) && (segm === want)) hits++;
            if ((sel !== exp_sel) || (segm !== exp_segm) || (frame_tick !== exp_tick)) mm++;
        end
        n_tests++;
        if (hits != 11) begin n_fail++; $display("FAIL hex_lit_cycles: got %0d want 11", hits); end
        n_tests++;
        if (mm != 0) begin n_fail++; $display("FAIL model_hex: got %0d mismatching cycles want 0", mm); end
    endtask

    task automatic test_raw_brightness();
        int hits;
        int lit;
        int mm;
        logic [7:0] want;
        want = ~8'h49;
        brightness = 2'd2;
        drive_write(2'd0, 8'h49, 1'b1);
        @(negedge clk);
        hits = 0;
        mm = 0;
        repeat (64) begin
            @(negedge clk);
            if ((sel === 4'b1110) && (segm === want)) hits++;
            if ((sel !== exp_sel) || (segm !== exp_segm) || (frame_tick !== exp_tick)) mm++;
        end
        n_tests++;
        if (hits != 7) begin n_fail++; $display("FAIL raw_lit_cycles: got %0d want 7", hits); end
        brightness = 2'd0;
        @(negedge clk);
        lit = 0;
        repeat (64) begin
            @(negedge clk);
            if ((sel !== 4'hF) || (segm !== 8'hFF)) lit++;
            if ((sel !== exp_sel) || (segm !== exp_segm) || (frame_tick !== exp_tick)) mm++;
        end
        n_tests++;
        if (lit != 0) begin n_fail++; $display("FAIL bright0_lit_cycles: got %0d want 0", lit); end
        n_tests++;
        if (mm != 0) begin n_fail++; $display("FAIL model_raw: got %0d mismatching cycles want 0", mm); end
    endtask

    task automatic test_out_of_range_enable();
        int bad;
        int hits;
        int n;
        logic [7:0] want8;
        want8 = ~8'h7F;
        brightness = 2'd3;
        enable = 1'b1;
        drive_write5(3'd5, 8'h88, 1'b0);
        drive_write5(3'd6, 8'h08, 1'b0);
        drive_write5(3'd7, 8'hFF, 1'b1);
        bad = 0;
        repeat (80) begin
            @(negedge clk);
            if (segm5 !== 8'hFF) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL oob_write_visible: got %0d lit-segment cycles want 0", bad); end
        drive_write5(3'd4, 8'h08, 1'b0);
        hits = 0;
        repeat (80) begin
            @(negedge clk);
            if ((sel5 === 5'b01111) && (segm5 === want8)) hits++;
        end
        n_tests++;
        if (hits != 11) begin n_fail++; $display("FAIL last_digit_write: got %0d lit cycles want 11", hits); end

        enable = 1'b0;
        @(negedge clk);
        n_tests++;
        if ((sel !== 4'hF) || (segm !== 8'hFF)) begin
            n_fail++; $display("FAIL disable_latency: got sel=%h segm=%h want F/FF", sel, segm);
        end
        bad = 0;
        n = 0;
        while ((frame_tick !== 1'b1) && (n < 100)) begin
            @(negedge clk);
            n++;
            if ((sel !== 4'hF) || (segm !== 8'hFF)) bad++;
        end
        n_tests++;
        if (frame_tick !== 1'b1) begin n_fail++; $display("FAIL disabled_tick_seen: got no tick in %0d cycles want tick", n); end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if ((sel !== 4'hF) || (segm !== 8'hFF)) bad++;
        end while ((frame_tick !== 1'b1) && (n < 200));
        n_tests++;
        if (n != 64) begin n_fail++; $display("FAIL disabled_tick_period: got %0d want 64", n); end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL disabled_outputs: got %0d active cycles want 0", bad); end
        enable = 1'b1;
    endtask

    task automatic test_write_during_lit();
        int n;
        logic [7:0] want1;
        logic [7:0] want7;
        want1 = ~8'h06;
        want7 = ~8'h07;
        brightness = 2'd3;
        enable = 1'b1;
        drive_write(2'd1, 8'h01, 1'b0);
        n = 0;
        while ((sel !== 4'b1101) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (sel !== 4'b1101) begin
            n_fail++; $display("FAIL wdl_find_digit1: got sel=%h want D within 100 cycles", sel);
        end else begin
            wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h07; wr_raw = 1'b0;
            @(negedge clk);
            wr_en = 1'b0;
            n_tests++;
            if ((sel !== 4'b1101) || (segm !== want1)) begin
                n_fail++; $display("FAIL wdl_edge_n: got sel=%h segm=%h want D/%h", sel, segm, want1);
            end
            @(negedge clk);
            n_tests++;
            if ((sel !== 4'b1101) || (segm !== want7)) begin
                n_fail++; $display("FAIL wdl_edge_n1: got sel=%h segm=%h want D/%h", sel, segm, want7);
            end
        end
    endtask

    task automatic test_random();
        int mm;
        mm = 0;
        repeat (800) begin
            @(negedge clk);
            if ((sel !== exp_sel) || (segm !== exp_segm) || (frame_tick !== exp_tick)) begin
                if (mm == 0) $display("FAIL random_first: got %h/%h/%b want %h/%h/%b",
                                      sel, segm, frame_tick, exp_sel, exp_segm, exp_tick);
                mm++;
            end
            wr_en   = ($urandom_range(3, 0) == 0);
            wr_addr = 2'($urandom_range(3, 0));
            wr_data = 8'($urandom);
            wr_raw  = 1'($urandom_range(1, 0));
            if ($urandom_range(31, 0) == 0) brightness = 2'($urandom_range(3, 0));
            if ($urandom_range(49, 0) == 0) enable = ~enable;
        end
        wr_en = 1'b0;
        n_tests++;
        if (mm != 0) begin n_fail++; $display("FAIL model_random: got %0d mismatching cycles want 0", mm); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_hex_decode();
        test_raw_brightness();
        test_out_of_range_enable();
        test_write_during_lit();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
